// File: rtl/apb_regbank_completer.sv
// apb_regbank_completer
// APB4 completer that fronts a bank of NUM_REGS registers, each DATA_WIDTH
// bits wide. It tracks the SETUP/ACCESS phases, inserts a programmable
// number of wait states, merges byte strobes on writes, and reports errors
// on PSLVERR (misaligned or out-of-range addresses, writes to read-only
// registers, privileged registers accessed without pprot[0], reads that
// carry strobes).
//
// Ports:
//   pclk     in   APB clock
//   presetn  in   asynchronous active-low reset
//   psel     in   completer select
//   penable  in   access-phase indicator
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address [ADDR_WIDTH]
//   pwdata   in   write data [DATA_WIDTH]
//   pstrb    in   write byte strobes [DATA_WIDTH/8]
//   pprot    in   protection type [3]
//   prdata   out  read data [DATA_WIDTH], registered, zero when idle
//   pready   out  transfer completion, registered
//   pslverr  out  transfer error, registered
//
// Optional build macro APB_REGBANK_WSCFG_EN: register NUM_REGS-1 becomes a
// wait-state configuration register. Its bits [3:0] set the wait count of
// every following transfer, upper bits read as zero, it ignores RO_MASK and
// it resets to WAIT_STATES.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transfer; a setup phase captures the request
// WAIT  | access phase, pready low while cnt counts down to 1
// DONE  | pready high for one cycle; write committed at the end of it

module apb_regbank_completer #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [NUM_REGS-1:0]   PRIV_MASK   = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [2:0]              pprot,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int ALIGN   = $clog2(STRB_W);
    localparam int IDX_W   = ADDR_WIDTH - ALIGN;
    localparam int REG_IW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CFG_IDX = NUM_REGS - 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << ALIGN) - 1);

`ifdef APB_REGBANK_WSCFG_EN
    // The configuration register stays writable whatever RO_MASK says.
    localparam logic [NUM_REGS-1:0] RO_EFF = RO_MASK & ~(NUM_REGS'(1) << CFG_IDX);
`else
    localparam logic [NUM_REGS-1:0] RO_EFF = RO_MASK;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } stateType;

    stateType              state;
    logic [3:0]            cnt;
    logic [REG_IW-1:0]     regIdxQ;
    logic                  writeQ;
    logic                  errQ;
    logic [DATA_WIDTH-1:0] wdataQ;
    logic [STRB_W-1:0]     strbQ;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic [IDX_W-1:0]      setupIdx;
    logic [REG_IW-1:0]     setupRegIdx;
    logic                  inRange;
    logic                  misaligned;
    logic                  roHit;
    logic                  privHit;
    logic                  setupErr;
    logic [3:0]            waitLoad;
    logic                  accessLive;
    logic [DATA_WIDTH-1:0] mergedWord;
    logic                  unusedProt;

    assign unusedProt  = ^pprot[2:1];

    assign setupIdx    = paddr[ADDR_WIDTH-1:ALIGN];
    assign setupRegIdx = setupIdx[REG_IW-1:0];
    assign inRange     = 32'(setupIdx) < NUM_REGS;
    assign misaligned  = |(paddr & ALIGN_MASK);
    // Mask lookups only matter when the index is in range.
    assign roHit       = inRange && RO_EFF[setupRegIdx];
    assign privHit     = inRange && PRIV_MASK[setupRegIdx] && !pprot[0];
    assign setupErr    = misaligned || !inRange || (pwrite && roHit) || privHit ||
                         (!pwrite && (|pstrb));
    assign accessLive  = psel && penable;

`ifdef APB_REGBANK_WSCFG_EN
    assign waitLoad = regs[CFG_IDX][3:0];
`else
    assign waitLoad = 4'(WAIT_STATES);
`endif

    always_comb begin
        mergedWord = regs[regIdxQ];
        for (int b = 0; b < STRB_W; b++) begin
            if (strbQ[b]) begin
                mergedWord[8*b +: 8] = wdataQ[8*b +: 8];
            end
        end
`ifdef APB_REGBANK_WSCFG_EN
        if (32'(regIdxQ) == CFG_IDX) begin
            mergedWord[DATA_WIDTH-1:4] = '0;
        end
`endif
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            regIdxQ <= '0;
            writeQ  <= 1'b0;
            errQ    <= 1'b0;
            wdataQ  <= '0;
            strbQ   <= '0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
`ifdef APB_REGBANK_WSCFG_EN
            regs[CFG_IDX] <= DATA_WIDTH'(WAIT_STATES);
`endif
        end else begin
            case (state)
                IDLE: begin
                    prdata  <= '0;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    // An access phase without a preceding setup is ignored.
                    if (psel && !penable) begin
                        regIdxQ <= setupRegIdx;
                        writeQ  <= pwrite;
                        errQ    <= setupErr;
                        wdataQ  <= pwdata;
                        strbQ   <= pstrb;
                        cnt     <= waitLoad;
                        if (waitLoad != 4'd0) begin
                            state <= WAIT;
                        end else begin
                            // Outputs are registered, so the response is
                            // loaded here to be visible in the first access cycle.
                            state   <= DONE;
                            pready  <= 1'b1;
                            pslverr <= setupErr;
                            prdata  <= (!pwrite && !setupErr) ? regs[setupRegIdx] : '0;
                        end
                    end
                end
                WAIT: begin
                    if (!accessLive) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state   <= DONE;
                            pready  <= 1'b1;
                            pslverr <= errQ;
                            prdata  <= (!writeQ && !errQ) ? regs[regIdxQ] : '0;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    prdata  <= '0;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    if (accessLive && writeQ && !errQ) begin
                        regs[regIdxQ] <= mergedWord;
                    end
                end
                default: begin
                    state   <= IDLE;
                    prdata  <= '0;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_regbank_completer.sv
module tb_apb_regbank_completer;

    localparam int              WS_A   = 0;
    localparam int              WS_B   = 3;
    localparam logic [15:0]     RO_A   = 16'h0000;
    localparam logic [15:0]     PRIV_A = 16'h0000;
    localparam logic [15:0]     RO_B   = 16'h0004;
    localparam logic [15:0]     PRIV_B = 16'h0008;
    localparam logic [31:0]     RST_A  = 32'h0000_0000;
    localparam logic [31:0]     RST_B  = 32'hA5A5_0000;
`ifdef APB_REGBANK_WSCFG_EN
    localparam bit CFG_EN = 1'b1;
`else
    localparam bit CFG_EN = 1'b0;
`endif

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          waits;
    } expT;

    logic        pclk;
    logic        presetn;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [7:0]  paddr   [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic [2:0]  pprot   [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    int          nChecks = 0;
    int          nFail   = 0;
    int          waitCnt [2];
    expT         q0[$];
    expT         q1[$];
    logic [31:0] mdl [2][16];

    apb_regbank_completer #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(16), .WAIT_STATES(WS_A),
        .RO_MASK(RO_A), .PRIV_MASK(PRIV_A), .RESET_VAL(RST_A)
    ) dutA (
        .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
        .pprot(pprot[0]), .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
    );

    apb_regbank_completer #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(16), .WAIT_STATES(WS_B),
        .RO_MASK(RO_B), .PRIV_MASK(PRIV_B), .RESET_VAL(RST_B)
    ) dutB (
        .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
        .pprot(pprot[1]), .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic int wsOf(input int d);
        return (d == 0) ? WS_A : WS_B;
    endfunction

    function automatic logic [15:0] roOf(input int d);
        return (d == 0) ? RO_A : RO_B;
    endfunction

    function automatic logic [15:0] privOf(input int d);
        return (d == 0) ? PRIV_A : PRIV_B;
    endfunction

    function automatic logic [31:0] rstOf(input int d);
        return (d == 0) ? RST_A : RST_B;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) mdl[d][i] = rstOf(d);
            if (CFG_EN) mdl[d][15] = 32'(wsOf(d));
        end
    endtask

    // Drives one complete transfer starting at a negedge; returns at a negedge
    // with psel low, so a following call produces a back-to-back transfer.
    task automatic xfer(input int d, input bit wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot);
        expT         e;
        int          idx;
        bit          err;
        bit          done;
        logic [15:0] ro;
        logic [15:0] pv;
        ro  = roOf(d);
        pv  = privOf(d);
        idx = int'(addr[7:2]);
        err = (addr[1:0] != 2'b00) || (idx >= 16);
        if (idx < 16) begin
            if (wr && ro[idx] && !(CFG_EN && idx == 15)) err = 1'b1;
            if (pv[idx] && !prot[0]) err = 1'b1;
        end
        if (!wr && strb != 4'h0) err = 1'b1;
        e.err   = err;
        e.rdata = 32'h0;
        if (!wr && !err) e.rdata = mdl[d][idx];
        e.waits = CFG_EN ? int'(mdl[d][15][3:0]) : wsOf(d);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        if (wr && !err) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[d][idx][8*b +: 8] = data[8*b +: 8];
            if (CFG_EN && idx == 15) mdl[d][idx] = mdl[d][idx] & 32'h0000_000F;
        end

        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr;
        pwdata[d] = data; pstrb[d] = strb; pprot[d] = prot;
        @(negedge pclk);
        penable[d] = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            if (pready[d]) done = 1'b1;
            else @(negedge pclk);
        end
        if (!done) begin
            nChecks++;
            nFail++;
            $display("FAIL timeout[%0d]: got no pready, expected pready within 40 cycles", d);
            if (d == 0) void'(q0.pop_back()); else void'(q1.pop_back());
        end
        @(negedge pclk);
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    task automatic monStep(input int d);
        expT e;
        if (psel[d] && penable[d]) begin
            if (pready[d]) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    nChecks++;
                    nFail++;
                    $display("FAIL unexpectedCompletion[%0d]: got pready=1, expected no transfer", d);
                end else begin
                    if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                    check($sformatf("pslverr[%0d]", d), 32'(pslverr[d]), 32'(e.err));
                    check($sformatf("prdata[%0d]", d), prdata[d], e.rdata);
                    check($sformatf("waitStates[%0d]", d), 32'(waitCnt[d]), 32'(e.waits));
                end
                waitCnt[d] = 0;
            end else begin
                waitCnt[d]++;
            end
        end else begin
            waitCnt[d] = 0;
            if (!penable[d])
                check($sformatf("idleOutputs[%0d]", d), {prdata[d][29:0], pready[d], pslverr[d]},
                      {prdata[d][29:0] & 30'h0, 2'b00} | 32'(prdata[d] != 32'h0) << 2);
        end
    endtask

    initial begin
        waitCnt[0] = 0;
        waitCnt[1] = 0;
        forever begin
            @(negedge pclk);
            #1;
            for (int d = 0; d < 2; d++) monStep(d);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          r;
        int          d;
        bit          wr;
        logic [7:0]  addr;
        logic [3:0]  strb;
        logic [2:0]  prot;

        presetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = 8'h0;
            pwdata[i] = 32'h0; pstrb[i] = 4'h0; pprot[i] = 3'b000;
        end
        modelReset();
        repeat (3) @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);

        // reset contents and basic write/read, back-to-back on dutA
        xfer(1, 1'b0, 8'h00, 32'h0, 4'h0, 3'b001);
        xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, 3'b001);
        xfer(0, 1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF, 3'b001);
        xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, 3'b001);
        // strobe merge
        xfer(0, 1'b1, 8'h04, 32'h1122_3344, 4'hF, 3'b001);
        xfer(0, 1'b1, 8'h04, 32'hAABB_CCDD, 4'b0101, 3'b001);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 3'b001);
        // zero-strobe write completes OKAY, leaves register alone
        xfer(0, 1'b1, 8'h04, 32'hFFFF_FFFF, 4'h0, 3'b001);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 3'b001);
        @(negedge pclk);

        // error decode on dutB (wait states 3, RO idx2, PRIV idx3)
        xfer(1, 1'b1, 8'h04, 32'h0102_0304, 4'hF, 3'b001);
        xfer(1, 1'b1, 8'h06, 32'hFFFF_FFFF, 4'hF, 3'b001);
        xfer(1, 1'b0, 8'h02, 32'h0, 4'h0, 3'b001);
        xfer(1, 1'b0, 8'h40, 32'h0, 4'h0, 3'b001);
        xfer(1, 1'b1, 8'h40, 32'h5555_5555, 4'hF, 3'b001);
        xfer(1, 1'b1, 8'h08, 32'h1234_5678, 4'hF, 3'b001);
        xfer(1, 1'b0, 8'h08, 32'h0, 4'h0, 3'b001);
        xfer(1, 1'b1, 8'h0C, 32'h7777_7777, 4'hF, 3'b001);
        xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, 3'b000);
        xfer(1, 1'b1, 8'h0C, 32'h8888_8888, 4'hF, 3'b000);
        xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, 3'b001);
        xfer(1, 1'b0, 8'h04, 32'h0, 4'h3, 3'b001);
        xfer(1, 1'b0, 8'h04, 32'h0, 4'h0, 3'b001);

        // access phase without setup is ignored
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 8'h04;
        pwdata[0] = 32'hCAFE_F00D; pstrb[0] = 4'hF; pprot[0] = 3'b001;
        repeat (3) @(negedge pclk);
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge pclk);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 3'b001);

        // abort: psel drops during WAIT, target unchanged
        xfer(1, 1'b1, 8'h18, 32'h1234_5678, 4'hF, 3'b001);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h18;
        pwdata[1] = 32'hFFFF_FFFF; pstrb[1] = 4'hF; pprot[1] = 3'b001;
        @(negedge pclk);
        penable[1] = 1'b1;
        @(negedge pclk);
        psel[1] = 1'b0; penable[1] = 1'b0;
        repeat (2) @(negedge pclk);
        xfer(1, 1'b0, 8'h18, 32'h0, 4'h0, 3'b001);

`ifdef APB_REGBANK_WSCFG_EN
        xfer(1, 1'b1, 8'h3C, 32'hFFFF_FFF2, 4'hF, 3'b001);
        xfer(1, 1'b0, 8'h00, 32'h0, 4'h0, 3'b001);
        xfer(1, 1'b0, 8'h3C, 32'h0, 4'h0, 3'b001);
        xfer(0, 1'b1, 8'h3C, 32'h0000_0002, 4'hF, 3'b001);
        xfer(0, 1'b0, 8'h3C, 32'h0, 4'h0, 3'b001);
`endif

        // randomized traffic on both completers
        for (int n = 0; n < 150; n++) begin
            d  = int'($urandom_range(0, 1));
            wr = ($urandom_range(0, 1) == 1);
            r  = int'($urandom_range(0, 19));
            if (r < 16)       addr = 8'(r * 4);
            else if (r == 16) addr = 8'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            else if (r == 17) addr = 8'($urandom_range(16, 63) * 4);
            else              addr = 8'($urandom_range(0, 15) * 4);
            if (wr) strb = 4'($urandom_range(0, 15));
            else    strb = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            prot    = 3'($urandom_range(0, 7));
            prot[0] = ($urandom_range(0, 3) != 0);
            xfer(d, wr, addr, $urandom, strb, prot);
            if ($urandom_range(0, 2) == 0) @(negedge pclk);
        end

        // asynchronous reset while dutA shows a response and dutB sits in WAIT
        xfer(0, 1'b1, 8'h04, 32'h1357_9BDF, 4'hF, 3'b001);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h14;
        pwdata[1] = 32'hFFFF_FFFF; pstrb[1] = 4'hF; pprot[1] = 3'b001;
        @(negedge pclk);
        penable[1] = 1'b1;
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 8'h04;
        pstrb[0] = 4'h0; pprot[0] = 3'b001;
        @(posedge pclk);
        #2;
        presetn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rstPready[%0d]", k), 32'(pready[k]), 32'h0);
            check($sformatf("rstPslverr[%0d]", k), 32'(pslverr[k]), 32'h0);
            check($sformatf("rstPrdata[%0d]", k), prdata[k], 32'h0);
        end
        @(negedge pclk);
        for (int k = 0; k < 2; k++) begin
            psel[k] = 1'b0; penable[k] = 1'b0;
        end
        @(negedge pclk);
        presetn = 1'b1;
        modelReset();
        @(negedge pclk);
        for (int i = 0; i < 16; i++) begin
            xfer(0, 1'b0, 8'(i * 4), 32'h0, 4'h0, 3'b001);
            xfer(1, 1'b0, 8'(i * 4), 32'h0, 4'h0, 3'b001);
        end

        repeat (4) @(negedge pclk);
        check("pendingA", 32'(q0.size()), 32'h0);
        check("pendingB", 32'(q1.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
